// File: rtl/avalon_st_fifo_rl.sv
// Packet-aware Avalon-ST FIFO with a configurable ready latency on sink and source.
// Stores {sop, eop, empty, data} per beat; reports fill level, thresholds and a sticky overflow flag.
module avalon_st_fifo_rl #(
    parameter int DATABITS_PER_SYMBOL = 8,
    parameter int SYMBOLS_PER_BEAT    = 4,
    parameter int EMPTY_W             = 2,
    parameter int DEPTH_LOG2          = 4,
    parameter int READY_LATENCY       = 2,
    parameter int ALMOST_FULL         = 12,
    parameter int ALMOST_EMPTY        = 2
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          flush_i,
    input  logic [DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] snk_data_i,
    input  logic                                          snk_valid_i,
    input  logic                                          snk_sop_i,
    input  logic                                          snk_eop_i,
    input  logic [EMPTY_W-1:0]                            snk_empty_i,
    output logic                                          snk_ready_o,
    output logic [DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] src_data_o,
    output logic                                          src_valid_o,
    output logic                                          src_sop_o,
    output logic                                          src_eop_o,
    output logic [EMPTY_W-1:0]                            src_empty_o,
    input  logic                                          src_ready_i,
    output logic [DEPTH_LOG2:0]                           usedw_o,
    output logic                                          almost_full_o,
    output logic                                          almost_empty_o,
    output logic                                          overflow_o
);

    localparam int DATA_W = DATABITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int PW     = DEPTH_LOG2 + 1;
    localparam int WORD_W = DATA_W + EMPTY_W + 2;
    localparam int SRW    = (READY_LATENCY == 0) ? 1 : READY_LATENCY;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              snk_ready_q, snk_ready_d;
    logic [SRW-1:0]    snk_sr_q, snk_sr_d;
    logic [SRW-1:0]    src_sr_q, src_sr_d;
    logic              overflow_q, overflow_d;

    logic              snk_grant;
    logic              src_grant;
    logic              fifo_empty;
    logic              wr_en;
    logic              rd_en;
    logic              src_valid;
    logic [PW-1:0]     usedw_next;
    logic [PW:0]       committed;

    // Handshake: a sink beat transfers when snk_valid_i is high in a cycle whose grant is
    // snk_ready_o from READY_LATENCY cycles earlier; a source beat transfers in every cycle
    // src_valid_o is high (RL>0), or when src_valid_o && src_ready_i (RL=0).
    always_comb begin
        snk_grant  = (READY_LATENCY == 0) ? snk_ready_q : snk_sr_q[SRW-1];
        src_grant  = (READY_LATENCY == 0) ? src_ready_i : src_sr_q[SRW-1];
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        if (READY_LATENCY == 0) begin
            src_valid = !fifo_empty && !flush_i;
            rd_en     = src_valid && src_ready_i;
        end else begin
            src_valid = src_grant && !fifo_empty && !flush_i;
            rd_en     = src_valid;
        end
        wr_en = snk_valid_i && snk_grant && !flush_i;

        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        rd_ptr_d = rd_ptr_q + PW'(rd_en);
        mem_d    = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = {snk_sop_i, snk_eop_i, snk_empty_i, snk_data_i};
        end

        if (READY_LATENCY == 0) begin
            snk_sr_d = '0;
            src_sr_d = '0;
        end else begin
            snk_sr_d = (snk_sr_q << 1) | SRW'(snk_ready_q);
            src_sr_d = (src_sr_q << 1) | SRW'(src_ready_i);
        end

        // Reserve a slot for every grant still travelling through the delay line.
        usedw_next = wr_ptr_d - rd_ptr_d;
        committed  = {1'b0, usedw_next};
        for (int i = 0; i < READY_LATENCY; i++) begin
            committed = committed + {{PW{1'b0}}, snk_sr_d[i]};
        end
        snk_ready_d = (committed < (PW+1)'(DEPTH));
        overflow_d  = overflow_q || (snk_valid_i && !snk_grant);

        if (flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            snk_sr_d    = '0;
            src_sr_d    = '0;
            snk_ready_d = 1'b0;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            snk_ready_q <= 1'b0;
            snk_sr_q    <= '0;
            src_sr_q    <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            snk_ready_q <= snk_ready_d;
            snk_sr_q    <= snk_sr_d;
            src_sr_q    <= src_sr_d;
            overflow_q  <= overflow_d;
            mem_q       <= mem_d;
        end
    end

    assign snk_ready_o = snk_ready_q && !flush_i;
    assign src_valid_o = src_valid;
    assign {src_sop_o, src_eop_o, src_empty_o, src_data_o} = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign usedw_o        = wr_ptr_q - rd_ptr_q;
    assign almost_full_o  = (usedw_o >= PW'(ALMOST_FULL));
    assign almost_empty_o = (usedw_o <= PW'(ALMOST_EMPTY));
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_avalon_st_fifo_rl.sv
// Bench for avalon_st_fifo_rl: RL=2 instance checked cycle by cycle against a queue model,
// plus an RL=0 instance checked with a simple expected-data queue.
module tb_avalon_st_fifo_rl;

    localparam int DW    = 32;
    localparam int EW    = 2;
    localparam int PW    = 5;
    localparam int DEPTH = 16;
    localparam int RL    = 2;
    localparam int AF    = 12;
    localparam int AE    = 2;
    localparam int WW    = DW + EW + 2;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // RL=2 instance
    logic          flush     = 1'b0;
    logic [DW-1:0] snk_data  = '0;
    logic          snk_valid = 1'b0;
    logic          snk_sop   = 1'b0;
    logic          snk_eop   = 1'b0;
    logic [EW-1:0] snk_empty = '0;
    logic          src_ready = 1'b0;
    logic          snk_ready, src_valid, src_sop, src_eop, af, ae, ovf;
    logic [DW-1:0] src_data;
    logic [EW-1:0] src_empty;
    logic [PW-1:0] usedw;

    avalon_st_fifo_rl #(.READY_LATENCY(RL)) dut (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
        .snk_data_i(snk_data), .snk_valid_i(snk_valid), .snk_sop_i(snk_sop),
        .snk_eop_i(snk_eop), .snk_empty_i(snk_empty), .snk_ready_o(snk_ready),
        .src_data_o(src_data), .src_valid_o(src_valid), .src_sop_o(src_sop),
        .src_eop_o(src_eop), .src_empty_o(src_empty), .src_ready_i(src_ready),
        .usedw_o(usedw), .almost_full_o(af), .almost_empty_o(ae), .overflow_o(ovf)
    );

    // RL=0 instance
    logic          z_flush     = 1'b0;
    logic [DW-1:0] z_snk_data  = '0;
    logic          z_snk_valid = 1'b0;
    logic          z_snk_sop   = 1'b0;
    logic          z_snk_eop   = 1'b0;
    logic [EW-1:0] z_snk_empty = '0;
    logic          z_src_ready = 1'b0;
    logic          z_snk_ready, z_src_valid, z_src_sop, z_src_eop, z_af, z_ae, z_ovf;
    logic [DW-1:0] z_src_data;
    logic [EW-1:0] z_src_empty;
    logic [PW-1:0] z_usedw;

    avalon_st_fifo_rl #(.READY_LATENCY(0)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .flush_i(z_flush),
        .snk_data_i(z_snk_data), .snk_valid_i(z_snk_valid), .snk_sop_i(z_snk_sop),
        .snk_eop_i(z_snk_eop), .snk_empty_i(z_snk_empty), .snk_ready_o(z_snk_ready),
        .src_data_o(z_src_data), .src_valid_o(z_src_valid), .src_sop_o(z_src_sop),
        .src_eop_o(z_src_eop), .src_empty_o(z_src_empty), .src_ready_i(z_src_ready),
        .usedw_o(z_usedw), .almost_full_o(z_af), .almost_empty_o(z_ae), .overflow_o(z_ovf)
    );

    // scoreboard state
    int n_checks = 0;
    int n_fail   = 0;
    int rx_cnt   = 0;

    logic [WW-1:0] exp_q[$];
    bit            snk_hist[$];
    bit            src_hist[$];
    bit            m_ready;
    bit            m_ovf;
    logic [DW-1:0] z_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        snk_hist.delete();
        src_hist.delete();
        for (int i = 0; i < RL; i++) begin
            snk_hist.push_back(1'b0);
            src_hist.push_back(1'b0);
        end
        m_ready = 1'b0;
        m_ovf   = 1'b0;
    endfunction

    function automatic bit m_snk_grant();
        return snk_hist[0];
    endfunction

    function automatic bit m_src_valid();
        return src_hist[0] && (exp_q.size() != 0) && !flush;
    endfunction

    // One clock of the reference: transfers, overflow, ready decision from the slot budget.
    function automatic void model_update();
        bit g = m_snk_grant();
        bit v = m_src_valid();
        int pend;
        if (flush) begin
            exp_q.delete();
            foreach (snk_hist[i]) snk_hist[i] = 1'b0;
            foreach (src_hist[i]) src_hist[i] = 1'b0;
            m_ready = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            if (v) void'(exp_q.pop_front());
            if (snk_valid && g) exp_q.push_back({snk_sop, snk_eop, snk_empty, snk_data});
            if (snk_valid && !g) m_ovf = 1'b1;
            snk_hist.push_back(m_ready);
            void'(snk_hist.pop_front());
            src_hist.push_back(src_ready);
            void'(src_hist.pop_front());
            pend = 0;
            foreach (snk_hist[i]) pend += int'(snk_hist[i]);
            m_ready = (exp_q.size() + pend) < DEPTH;
        end
    endfunction

    task automatic check_outputs();
        logic [WW-1:0] head;
        check_eq("snk_ready", snk_ready, m_ready && !flush);
        check_eq("src_valid", src_valid, m_src_valid());
        check_eq("usedw", usedw, exp_q.size());
        check_eq("almost_full", af, exp_q.size() >= AF);
        check_eq("almost_empty", ae, exp_q.size() <= AE);
        check_eq("overflow", ovf, m_ovf);
        if (m_src_valid()) begin
            head = exp_q[0];
            check_eq("src_beat", {src_sop, src_eop, src_empty, src_data}, head);
        end
    endtask

    // Inputs are set at posedge+1; outputs checked at negedge; model advanced at posedge.
    task automatic step();
        @(negedge clk);
        check_outputs();
        if (src_valid) rx_cnt++;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive_beat(input bit v, input bit sop, input bit eop,
                              input logic [EW-1:0] emp, input logic [DW-1:0] d);
        snk_valid = v;
        snk_sop   = sop;
        snk_eop   = eop;
        snk_empty = emp;
        snk_data  = d;
    endtask

    task automatic drive_random_if_granted();
        if (m_snk_grant())
            drive_beat(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       EW'($urandom_range(0, 3)), DW'($urandom));
        else
            drive_beat(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int sent;
        int npop;

        // reset values while held in reset
        #3;
        check_eq("rst_snk_ready", snk_ready, 1'b0);
        check_eq("rst_src_valid", src_valid, 1'b0);
        check_eq("rst_usedw", usedw, 0);
        check_eq("rst_almost_empty", ae, 1'b1);
        check_eq("rst_almost_full", af, 1'b0);
        check_eq("rst_overflow", ovf, 1'b0);
        check_eq("rst_src_data", src_data, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // single packet 0x11..0x16, held then drained
        src_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            if (idx < 6 && m_snk_grant()) begin
                drive_beat(1'b1, idx == 0, idx == 5, (idx == 5) ? 2'd1 : 2'd0, DW'(32'h11 + idx));
                idx++;
            end else begin
                drive_beat(1'b0, 1'b0, 1'b0, '0, '0);
            end
            step();
        end
        drive_beat(1'b0, 1'b0, 1'b0, '0, '0);
        check_eq("pkt_peak_usedw", usedw, 6);
        src_ready = 1'b1;
        rx_cnt = 0;
        repeat (12) step();
        check_eq("pkt_rx_count", rx_cnt, 6);
        check_eq("pkt_drained", usedw, 0);

        // fill with the source stalled
        src_ready = 1'b0;
        for (int c = 0; c < 30; c++) begin
            drive_random_if_granted();
            step();
        end
        drive_beat(1'b0, 1'b0, 1'b0, '0, '0);
        check_eq("fill_usedw", usedw, 16);
        check_eq("fill_almost_full", af, 1'b1);
        check_eq("fill_overflow", ovf, 1'b0);
        check_eq("fill_snk_ready", snk_ready, 1'b0);

        // both sides streaming: occupancy settles where used + 2 in-flight grants < 16
        src_ready = 1'b1;
        for (int c = 0; c < 55; c++) begin
            drive_random_if_granted();
            step();
            if (c >= 15) check_eq("wrap_usedw_const", usedw, 13);
        end

        // refill, then a beat with no grant
        src_ready = 1'b0;
        for (int c = 0; c < 25; c++) begin
            drive_random_if_granted();
            step();
        end
        drive_beat(1'b1, 1'b0, 1'b0, '0, 32'hdead_beef);
        step();
        drive_beat(1'b0, 1'b0, 1'b0, '0, '0);
        step();
        check_eq("ovf_set", ovf, 1'b1);
        check_eq("ovf_usedw", usedw, 16);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush_overflow", ovf, 1'b0);
        check_eq("flush_usedw", usedw, 0);
        step();

        // randomized traffic with occasional flushes and stray valids
        for (int c = 0; c < 500; c++) begin
            flush     = ($urandom_range(0, 59) == 0);
            src_ready = ($urandom_range(0, 3) != 0);
            if (!flush && m_snk_grant() && $urandom_range(0, 3) != 0)
                drive_beat(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           EW'($urandom_range(0, 3)), DW'($urandom));
            else if ($urandom_range(0, 199) == 0)
                drive_beat(1'b1, 1'b0, 1'b0, '0, DW'($urandom));
            else
                drive_beat(1'b0, 1'b0, 1'b0, '0, '0);
            step();
        end
        flush = 1'b0;

        // asynchronous reset in the middle of a packet
        src_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive_random_if_granted();
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_snk_ready", snk_ready, 1'b0);
        check_eq("arst_src_valid", src_valid, 1'b0);
        check_eq("arst_usedw", usedw, 0);
        check_eq("arst_almost_empty", ae, 1'b1);
        check_eq("arst_almost_full", af, 1'b0);
        check_eq("arst_overflow", ovf, 1'b0);
        check_eq("arst_src_payload", {src_sop, src_eop, src_empty, src_data}, 0);
        drive_beat(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step();
        check_eq("post_rst_usedw", usedw, 0);
        check_eq("post_rst_almost_empty", ae, 1'b1);
        repeat (4) step();

        // RL=0 instance: source ready toggles every cycle
        sent = 0;
        npop = 0;
        for (int c = 0; c < 380; c++) begin
            z_src_ready = ~z_src_ready;
            if (c < 300 && z_snk_ready && $urandom_range(0, 2) != 0) begin
                z_snk_valid = 1'b1;
                z_snk_data  = DW'(sent);
                sent++;
            end else begin
                z_snk_valid = 1'b0;
            end
            @(negedge clk);
            check_eq("rl0_valid", z_src_valid, z_q.size() != 0);
            if (z_src_valid && z_src_ready) begin
                if (z_q.size() != 0) begin
                    check_eq("rl0_data", z_src_data, z_q[0]);
                    void'(z_q.pop_front());
                end
                npop++;
            end
            if (z_snk_valid && z_snk_ready) z_q.push_back(z_snk_data);
            @(posedge clk);
            #1;
        end
        z_snk_valid = 1'b0;
        check_eq("rl0_all_popped", npop, sent);
        check_eq("rl0_queue_empty", z_q.size(), 0);
        check_eq("rl0_overflow", z_ovf, 1'b0);
        check_eq("rl0_usedw", z_usedw, 0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
